// File: rtl/riscv_pkg.sv
// Shared constants for the single-cycle RISC-V core: register-file geometry,
// ABI register indices and ALU select encodings.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 2 ** REG_ADDR_W;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;
  localparam logic [REG_ADDR_W-1:0] REG_RA = 5'd1;
  localparam logic [REG_ADDR_W-1:0] REG_SP = 5'd2;
  localparam logic [REG_ADDR_W-1:0] REG_GP = 5'd3;
  localparam logic [REG_ADDR_W-1:0] REG_TP = 5'd4;
  localparam logic [REG_ADDR_W-1:0] REG_T0 = 5'd5;
  localparam logic [REG_ADDR_W-1:0] REG_T1 = 5'd6;
  localparam logic [REG_ADDR_W-1:0] REG_T2 = 5'd7;
  localparam logic [REG_ADDR_W-1:0] REG_S0 = 5'd8;
  localparam logic [REG_ADDR_W-1:0] REG_S1 = 5'd9;
  localparam logic [REG_ADDR_W-1:0] REG_A0 = 5'd10;
  localparam logic [REG_ADDR_W-1:0] REG_A1 = 5'd11;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_EQ  = 4'b1111
  } alu_sel_e;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: x0 masking plus an optional
// same-cycle write-to-read forwarding path.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_COUNT,
  parameter int BYPASS   = 0
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]               addr,
  input  logic                            wr_en,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [DATA_W-1:0]               data
);

  logic is_zero;
  logic hit;

  assign is_zero = (addr == '0);
  // Constant-folds away when BYPASS=0, leaving a plain array read.
  assign hit     = (BYPASS != 0) && wr_en && (wr_addr != '0) && (wr_addr == addr);

  always_comb begin
    data = regs[addr];
    if (hit)     data = wr_data;
    if (is_zero) data = '0;
  end

endmodule

// File: rtl/reg_file_32.sv
// 32 x 32 integer register file: one clocked storage array, three
// combinational read ports (rs1, rs2, debug), x0 hard-wired to zero.
module reg_file_32
  import riscv_pkg::*;
#(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_COUNT,
  parameter int BYPASS   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_PORTS = 3;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [ADDR_W-1:0]               port_addr [NUM_PORTS];
  logic [DATA_W-1:0]               port_data [NUM_PORTS];

  // Reset has priority over a coincident write and clears every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '0;
    end else if (reg_write && (rd_addr != '0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign port_addr[0] = rs1_addr;
  assign port_addr[1] = rs2_addr;
  assign port_addr[2] = dbg_addr;

  // Port 2 is the debug port and never forwards.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      rf_read_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .BYPASS   ((gi < 2) ? BYPASS : 0)
      ) u_port (
        .regs    (regs),
        .addr    (port_addr[gi]),
        .wr_en   (reg_write),
        .wr_addr (rd_addr),
        .wr_data (rd_data),
        .data    (port_data[gi])
      );
    end
  endgenerate

  assign rs1_data = port_data[0];
  assign rs2_data = port_data[1];
  assign dbg_data = port_data[2];

endmodule

// File: tb/tb_reg_file_32.sv
// Directed plus random bench for reg_file_32, run side by side with BYPASS=0
// and BYPASS=1 instances sharing the same stimulus.
module tb_reg_file_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, dbg_addr;
  logic        reg_write;
  logic [31:0] rd_data;
  logic [31:0] rs1_data0, rs2_data0, dbg_data0;
  logic [31:0] rs1_data1, rs2_data1, dbg_data1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_32 #(.BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data0), .rs2_data(rs2_data0),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data0)
  );

  reg_file_32 #(.BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data1), .rs2_data(rs2_data1),
    .reg_write(reg_write), .rd_addr(rd_addr), .rd_data(rd_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data1)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model [32];
  logic [31:0] sum;
  logic [31:0] exp_b1, exp_b2;
  int          same_hits;

  initial begin
    rst_n = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    step();

    // 1. Reset clears a previously written entry, and every entry reads 0.
    rst_n = 1'b1; reg_write = 1'b1; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
    step();
    reg_write = 1'b0; dbg_addr = 5'd5; #1;
    check("pre_reset_x5", dbg_data0, 32'hDEADBEEF);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
    check("reset_rs1_x5", rs1_data0, 32'h0);
    check("reset_rs2_x5", rs2_data0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      check($sformatf("reset_dbg_x%0d", i), dbg_data0, 32'h0);
      check($sformatf("reset_dbg_byp_x%0d", i), dbg_data1, 32'h0);
    end

    // 2. Write/read, then ADD on the two operands gives zero.
    reg_write = 1'b1; rd_addr = 5'd1; rd_data = 32'h00000007; step();
    rd_addr = 5'd2; rd_data = 32'hFFFFFFF9; step();
    reg_write = 1'b0; rs1_addr = 5'd1; rs2_addr = 5'd2; #1;
    check("wr_rs1_x1", rs1_data0, 32'h00000007);
    check("wr_rs2_x2", rs2_data0, 32'hFFFFFFF9);
    sum = rs1_data0 + rs2_data0;
    check("alu_add_out", sum, 32'h0);
    check("alu_add_zero", {31'b0, (sum == 32'h0)}, 32'h1);

    // 3. Writes to x0 are dropped; x0 reads 0 even on the forwarding instance.
    reg_write = 1'b1; rd_addr = 5'd0; rd_data = 32'h12345678; rs1_addr = 5'd0; #1;
    check("x0_during_wr_byp", rs1_data1, 32'h0);
    check("x0_during_wr", rs1_data0, 32'h0);
    step();
    reg_write = 1'b0; #1;
    check("x0_after_wr", rs1_data0, 32'h0);
    check("x0_after_wr_byp", rs1_data1, 32'h0);

    // 4. Read-during-write: old data without bypass, new data with bypass.
    reg_write = 1'b1; rd_addr = 5'd3; rd_data = 32'h11; step();
    rd_data = 32'h22; rs1_addr = 5'd3; #1;
    check("rdw_old_data", rs1_data0, 32'h11);
    check("rdw_bypass", rs1_data1, 32'h22);
    step();
    reg_write = 1'b0; #1;
    check("rdw_after_edge", rs1_data0, 32'h22);

    // 5. Reset wins over a coincident write and clears everything.
    rst_n = 1'b0; reg_write = 1'b1; rd_addr = 5'd4; rd_data = 32'hAA; step();
    rst_n = 1'b1; reg_write = 1'b0; dbg_addr = 5'd4; rs1_addr = 5'd3; rs2_addr = 5'd1; #1;
    check("rst_vs_wr_x4", dbg_data0, 32'h0);
    check("rst_clears_x3", rs1_data0, 32'h0);
    check("rst_clears_x1", rs2_data0, 32'h0);

    // 6. Random traffic against a scoreboard.
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    same_hits = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      reg_write = 1'($urandom_range(0, 1));
      rd_data   = $urandom;
      rd_addr   = 5'($urandom_range(0, 31));
      rs1_addr  = 5'($urandom_range(0, 31));
      rs2_addr  = 5'($urandom_range(0, 31));
      dbg_addr  = 5'($urandom_range(0, 31));
      if ((cyc % 8) == 0) begin
        rs1_addr = rd_addr; rs2_addr = rd_addr;
      end
      if (rs1_addr == rs2_addr && rs2_addr == rd_addr) same_hits++;
      #1;
      exp_b1 = (reg_write && rd_addr != 0 && rd_addr == rs1_addr) ? rd_data : model[rs1_addr];
      exp_b2 = (reg_write && rd_addr != 0 && rd_addr == rs2_addr) ? rd_data : model[rs2_addr];
      check($sformatf("rnd%0d_rs1", cyc), rs1_data0, model[rs1_addr]);
      check($sformatf("rnd%0d_rs2", cyc), rs2_data0, model[rs2_addr]);
      check($sformatf("rnd%0d_dbg", cyc), dbg_data0, model[dbg_addr]);
      check($sformatf("rnd%0d_rs1_byp", cyc), rs1_data1, exp_b1);
      check($sformatf("rnd%0d_rs2_byp", cyc), rs2_data1, exp_b2);
      check($sformatf("rnd%0d_dbg_byp", cyc), dbg_data1, model[dbg_addr]);
      step();
      if (reg_write && rd_addr != 0) model[rd_addr] = rd_data;
    end
    check("same_addr_hits_ge_50", {31'b0, (same_hits >= 50)}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
